// File: rtl/product_inventory_bank.sv
// Per-slot saturating stock counters for the vending machine, with restock
// from the service port and a req/ack/nack dispense handshake.
module product_inventory_bank #(
    parameter int unsigned N_SLOTS   = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned MAX_COUNT = 15,
    parameter int unsigned SEL_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               restock_en,
    input  logic [SEL_W-1:0]   restock_slot,
    input  logic [CNT_W-1:0]   restock_qty,
    output logic               restock_ovf,
    input  logic               disp_req,
    input  logic [SEL_W-1:0]   disp_slot,
    output logic               disp_ack,
    output logic               disp_nack,
    output logic               busy,
    input  logic [SEL_W-1:0]   rd_slot,
    output logic [CNT_W-1:0]   rd_count,
    output logic [N_SLOTS-1:0] empty_vec
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_W:0]   MAX_SUM = (CNT_W+1)'(MAX_COUNT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_q [N_SLOTS];
    logic [CNT_W-1:0] count_d [N_SLOTS];
    logic [1:0]       state_q;
    logic [SEL_W-1:0] slot_q;
    logic             ack_q;
    logic             nack_q;
    logic             ovf_q;
    logic             grant;
    logic             ovf_d;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] base;

    // Restock saturates first, then a granted dispense takes one off the
    // saturated value; out-of-range slot indices match no slot at all.
    always_comb begin
        grant = 1'b0;
        ovf_d = 1'b0;
        sum   = '0;
        base  = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            sum  = {1'b0, count_q[i]} + {1'b0, restock_qty};
            base = count_q[i];
            if (restock_en && restock_slot == SEL_W'(i)) begin
                base  = (sum > MAX_SUM) ? MAX_CNT : sum[CNT_W-1:0];
                ovf_d = (sum > MAX_SUM);
            end
            if (state_q == ST_CHECK && slot_q == SEL_W'(i) && count_q[i] != '0) begin
                grant = 1'b1;
                base  = base - CNT_W'(1);
            end
            count_d[i] = base;
        end
    end

    always_comb begin
        rd_count = '0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (rd_slot == SEL_W'(i)) begin
                rd_count = count_q[i];
            end
            empty_vec[i] = (count_q[i] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                count_q[i] <= '0;
            end
            state_q <= ST_IDLE;
            slot_q  <= '0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                count_q[i] <= count_d[i];
            end
            ovf_q  <= ovf_d;
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (disp_req) begin
                        slot_q  <= disp_slot;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    ack_q   <= grant;
                    nack_q  <= !grant;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!disp_req) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign restock_ovf = ovf_q;
    assign disp_ack    = ack_q;
    assign disp_nack   = nack_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_product_inventory_bank.sv
// Directed, table-driven check of product_inventory_bank: restock saturation,
// dispense handshake timing, empty/invalid nacks, collisions and reset mid-request.
module tb_product_inventory_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       restock_en;
    logic [2:0] restock_slot;
    logic [3:0] restock_qty;
    logic       restock_ovf;
    logic       disp_req;
    logic [2:0] disp_slot;
    logic       disp_ack;
    logic       disp_nack;
    logic       busy;
    logic [2:0] rd_slot;
    logic [3:0] rd_count;
    logic [3:0] empty_vec;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    product_inventory_bank #(
        .N_SLOTS  (4),
        .CNT_W    (4),
        .MAX_COUNT(15),
        .SEL_W    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .restock_en  (restock_en),
        .restock_slot(restock_slot),
        .restock_qty (restock_qty),
        .restock_ovf (restock_ovf),
        .disp_req    (disp_req),
        .disp_slot   (disp_slot),
        .disp_ack    (disp_ack),
        .disp_nack   (disp_nack),
        .busy        (busy),
        .rd_slot     (rd_slot),
        .rd_count    (rd_count),
        .empty_vec   (empty_vec)
    );

    typedef struct {
        logic       ren;
        logic [2:0] rslot;
        logic [3:0] rqty;
        logic       req;
        logic [2:0] dslot;
        logic [2:0] rdslot;
        logic [3:0] cnt;
        logic       ovf;
        logic       ack;
        logic       nack;
        logic       bsy;
        logic [3:0] empty;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic ren, input logic [2:0] rslot, input logic [3:0] rqty,
                                input logic req, input logic [2:0] dslot, input logic [2:0] rdslot,
                                input logic [3:0] cnt, input logic ovf, input logic ack,
                                input logic nack, input logic bsy, input logic [3:0] empty);
        vec_t v;
        v = '{ren, rslot, rqty, req, dslot, rdslot, cnt, ovf, ack, nack, bsy, empty};
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        restock_en   = 1'b0;
        restock_slot = '0;
        restock_qty  = '0;
        disp_req     = 1'b0;
        disp_slot    = '0;
    endtask

    initial begin
        // T1: reset with random inputs
        reset = 1'b0;
        rd_slot = '0;
        for (int k = 0; k < 2; k++) begin
            restock_en   = 1'($urandom);
            restock_slot = 3'($urandom);
            restock_qty  = 4'($urandom);
            disp_req     = 1'($urandom);
            disp_slot    = 3'($urandom);
            tick();
        end
        chk("rst_empty", 32'(empty_vec), 32'hF);
        chk("rst_ack",   32'(disp_ack), 0);
        chk("rst_nack",  32'(disp_nack), 0);
        chk("rst_ovf",   32'(restock_ovf), 0);
        chk("rst_busy",  32'(busy), 0);
        for (int s = 0; s < 4; s++) begin
            rd_slot = 3'(s);
            #1;
            chk("rst_count", 32'(rd_count), 0);
        end
        idle_inputs();
        reset = 1'b1;
        tick();

        //  ren slot qty  req dslot rd | cnt ovf ack nack busy empty
        add(1, 2, 9,  0, 0, 2,  9,  0, 0, 0, 0, 4'b1011);
        add(1, 2, 9,  0, 0, 2,  15, 1, 0, 0, 0, 4'b1011);
        add(0, 0, 0,  0, 0, 2,  15, 0, 0, 0, 0, 4'b1011);
        add(1, 1, 3,  0, 0, 1,  3,  0, 0, 0, 0, 4'b1001);
        add(0, 0, 0,  1, 1, 1,  3,  0, 0, 0, 1, 4'b1001);
        add(0, 0, 0,  1, 1, 1,  2,  0, 1, 0, 1, 4'b1001);
        add(0, 0, 0,  1, 1, 1,  2,  0, 0, 0, 1, 4'b1001);
        add(0, 0, 0,  0, 0, 1,  2,  0, 0, 0, 0, 4'b1001);
        add(0, 0, 0,  1, 0, 0,  0,  0, 0, 0, 1, 4'b1001);
        add(0, 0, 0,  1, 0, 0,  0,  0, 0, 1, 1, 4'b1001);
        add(0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 0, 4'b1001);
        add(0, 0, 0,  1, 5, 5,  0,  0, 0, 0, 1, 4'b1001);
        add(0, 0, 0,  1, 5, 5,  0,  0, 0, 1, 1, 4'b1001);
        add(0, 0, 0,  0, 0, 5,  0,  0, 0, 0, 0, 4'b1001);
        add(1, 5, 9,  0, 0, 5,  0,  0, 0, 0, 0, 4'b1001);
        add(0, 0, 0,  0, 0, 1,  2,  0, 0, 0, 0, 4'b1001);
        add(1, 2, 0,  0, 0, 2,  15, 0, 0, 0, 0, 4'b1001);
        // T5 collisions in CHECK
        add(1, 3, 1,  0, 0, 3,  1,  0, 0, 0, 0, 4'b0001);
        add(0, 0, 0,  1, 3, 3,  1,  0, 0, 0, 1, 4'b0001);
        add(1, 3, 2,  1, 3, 3,  2,  0, 1, 0, 1, 4'b0001);
        add(0, 0, 0,  0, 0, 3,  2,  0, 0, 0, 0, 4'b0001);
        add(0, 0, 0,  1, 0, 0,  0,  0, 0, 0, 1, 4'b0001);
        add(1, 0, 2,  1, 0, 0,  2,  0, 0, 1, 1, 4'b0000);
        add(0, 0, 0,  0, 0, 0,  2,  0, 0, 0, 0, 4'b0000);
        add(0, 0, 0,  1, 2, 2,  15, 0, 0, 0, 1, 4'b0000);
        add(1, 2, 3,  1, 2, 2,  14, 1, 1, 0, 1, 4'b0000);
        add(0, 0, 0,  0, 0, 2,  14, 0, 0, 0, 0, 4'b0000);
        add(0, 0, 0,  1, 1, 1,  2,  0, 0, 0, 1, 4'b0000);
        add(1, 3, 4,  1, 1, 3,  6,  0, 1, 0, 1, 4'b0000);
        add(0, 0, 0,  0, 0, 1,  1,  0, 0, 0, 0, 4'b0000);

        foreach (tbl[i]) begin
            restock_en   = tbl[i].ren;
            restock_slot = tbl[i].rslot;
            restock_qty  = tbl[i].rqty;
            disp_req     = tbl[i].req;
            disp_slot    = tbl[i].dslot;
            rd_slot      = tbl[i].rdslot;
            tick();
            chk($sformatf("v%0d_count", i), 32'(rd_count),    32'(tbl[i].cnt));
            chk($sformatf("v%0d_ovf", i),   32'(restock_ovf), 32'(tbl[i].ovf));
            chk($sformatf("v%0d_ack", i),   32'(disp_ack),    32'(tbl[i].ack));
            chk($sformatf("v%0d_nack", i),  32'(disp_nack),   32'(tbl[i].nack));
            chk($sformatf("v%0d_busy", i),  32'(busy),        32'(tbl[i].bsy));
            chk($sformatf("v%0d_empty", i), 32'(empty_vec),   32'(tbl[i].empty));
        end

        // T6: reset during CHECK drops the request; held req restarts afterwards
        idle_inputs();
        disp_req  = 1'b1;
        disp_slot = 3'd0;
        rd_slot   = 3'd0;
        tick();
        chk("t6_busy_check", 32'(busy), 1);
        reset = 1'b0;
        tick();
        chk("t6_rst_ack",   32'(disp_ack), 0);
        chk("t6_rst_nack",  32'(disp_nack), 0);
        chk("t6_rst_busy",  32'(busy), 0);
        chk("t6_rst_count", 32'(rd_count), 0);
        chk("t6_rst_empty", 32'(empty_vec), 32'hF);
        reset = 1'b1;
        tick();
        chk("t6_new_busy", 32'(busy), 1);
        chk("t6_new_ack",  32'(disp_ack), 0);
        chk("t6_new_nack", 32'(disp_nack), 0);
        tick();
        chk("t6_nack",     32'(disp_nack), 1);
        chk("t6_no_ack",   32'(disp_ack), 0);
        disp_req = 1'b0;
        tick();
        chk("t6_idle",      32'(busy), 0);
        chk("t6_nack_done", 32'(disp_nack), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
